// File: rtl/deaggregator_v2.sv
// deaggregator_v2: buffers wide words from a 1-cycle-latency source and
// serialises them lane by lane into an enq/full_n FIFO, with per-word lane
// count, selectable lane order and end-of-frame propagation.
module deaggregator_v2 #(
   parameter int DATA_WIDTH  = 16,
   parameter int FETCH_WIDTH = 4,
   parameter int BUF_DEPTH   = 3,
   parameter int LANE_ORDER  = 0,
   localparam int CW = $clog2(FETCH_WIDTH + 1),
   localparam int OW = $clog2(BUF_DEPTH + 1)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data,
   input  logic [CW-1:0]                     sender_count,
   input  logic                              sender_last,
   input  logic                              sender_empty_n,
   output logic                              sender_deq,
   output logic [DATA_WIDTH-1:0]             receiver_data,
   output logic                              receiver_last,
   input  logic                              receiver_full_n,
   output logic                              receiver_enq,
   output logic [OW-1:0]                     occupancy
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int KW = $clog2(FETCH_WIDTH);

   // Word buffer (data only, never reset; validity is tracked by r_fill)
   logic [FETCH_WIDTH*DATA_WIDTH-1:0] r_data [BUF_DEPTH];
   logic [CW-1:0]                     r_cnt  [BUF_DEPTH];
   logic                              r_last [BUF_DEPTH];

   logic [PW-1:0] r_wptr, r_rptr;
   logic [OW-1:0] r_fill;   // words actually captured and not yet retired
   logic [OW-1:0] r_occ;    // credits: captured words plus the one in flight
   logic          r_deq;    // a read issued last cycle returns data now
   logic [KW-1:0] r_k;      // lane index within the head word

   logic                              w_deq, w_enq, w_retire, w_nonempty;
   logic                              w_head_zero, w_lane_end;
   logic [CW-1:0]                     w_head_cnt, w_cnt_in;
   logic [FETCH_WIDTH*DATA_WIDTH-1:0] w_head_word;
   logic [DATA_WIDTH-1:0]             w_lanes [FETCH_WIDTH];
   logic [KW-1:0]                     w_idx;

   // Modulo wrap so non-power-of-2 depths work
   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_nonempty  = (r_fill != '0);
   assign w_head_word = r_data[r_rptr];
   assign w_head_cnt  = r_cnt[r_rptr];
   assign w_head_zero = (w_head_cnt == '0);
   assign w_lane_end  = (CW'(r_k) == w_head_cnt - CW'(1));

   // Oversized counts are clamped on the way in so the emit side never sees them
   assign w_cnt_in = (sender_count > CW'(FETCH_WIDTH)) ? CW'(FETCH_WIDTH) : sender_count;

   assign w_deq    = !rst && sender_empty_n && (r_occ < OW'(BUF_DEPTH));
   assign w_enq    = !rst && receiver_full_n && w_nonempty && !w_head_zero;
   // A zero-count head is dropped without emitting anything
   assign w_retire = !rst && w_nonempty && ((w_enq && w_lane_end) || w_head_zero);

   for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
      assign w_lanes[g] = w_head_word[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign w_idx = (LANE_ORDER != 0) ? KW'(FETCH_WIDTH - 1) - r_k : r_k;

   assign sender_deq    = w_deq;
   assign receiver_enq  = w_enq;
   assign receiver_data = w_lanes[w_idx];
   assign receiver_last = w_enq && w_lane_end && r_last[r_rptr];
   assign occupancy     = r_occ;

   // Capture the word returned by the source one cycle after the read request
   always_ff @(posedge clk) begin
      if (r_deq) begin
         r_data[r_wptr] <= sender_data;
         r_cnt[r_wptr]  <= w_cnt_in;
         r_last[r_wptr] <= sender_last;
      end
   end

   // Pointers, fill level, credits and lane index; reset drops everything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fill <= '0;
         r_occ  <= '0;
         r_deq  <= 1'b0;
         r_k    <= '0;
      end else begin
         r_deq <= w_deq;
         if (r_deq)
            r_wptr <= f_next(r_wptr);
         if (w_retire)
            r_rptr <= f_next(r_rptr);
         case ({r_deq, w_retire})
            2'b10:   r_fill <= r_fill + OW'(1);
            2'b01:   r_fill <= r_fill - OW'(1);
            default: r_fill <= r_fill;
         endcase
         case ({w_deq, w_retire})
            2'b10:   r_occ <= r_occ + OW'(1);
            2'b01:   r_occ <= r_occ - OW'(1);
            default: r_occ <= r_occ;
         endcase
         if (w_retire)
            r_k <= '0;
         else if (w_enq)
            r_k <= r_k + KW'(1);
      end
   end

endmodule

// File: doc/deaggregator_v2.md
Name: deaggregator_v2

Overview:
- Parametrised successor to the fixed-depth word deaggregator.
- Pulls wide words (FETCH_WIDTH lanes) from a 1-cycle-read-latency source such as a double buffer, and serialises them lane-by-lane into a narrow enq/full_n interface FIFO.
- Adds configurable buffer depth, per-word valid lane count (partial words), selectable lane order, and end-of-frame propagation.
- Sits between memory/double-buffer readers and per-lane compute FIFOs.

Parameters:
- DATA_WIDTH, 16, bits per lane.
- FETCH_WIDTH, 4, lanes per sender word; any value >= 2 (not restricted to powers of 2).
- BUF_DEPTH, 3, wide words held internally; >= 2.
- LANE_ORDER, 0, 0 = lane 0 (LSBs) emitted first; 1 = lane FETCH_WIDTH-1 (MSBs) emitted first.
- CW (local), clog2(FETCH_WIDTH+1), width of lane count.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- sender_data  in  FETCH_WIDTH*DATA_WIDTH  wide word; valid the cycle after sender_deq.
- sender_count  in  CW  valid lanes in word, 0..FETCH_WIDTH; same timing as sender_data.
- sender_last  in  1  word ends a frame; same timing as sender_data.
- sender_empty_n  in  1  source has a word.
- sender_deq  out  1  read request to source.
- receiver_data  out  DATA_WIDTH  current lane.
- receiver_last  out  1  final emitted lane of a sender_last word.
- receiver_full_n  in  1  receiver has space.
- receiver_enq  out  1  lane transfer.
- occupancy  out  clog2(BUF_DEPTH+1)  credits in use (buffered + in-flight words).

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at clk edge): buffer pointers, lane index, credit counter and the in-flight flag all cleared.
- While rst=1, sender_deq=0 and receiver_enq=0 combinationally.
- Reset mid-operation discards all buffered and in-flight words. Data returned by the source the cycle after reset is ignored.
- Credits: occupancy increments on sender_deq, decrements on word retire; simultaneous deq+retire leaves it unchanged.
- sender_deq = !rst && sender_empty_n && occupancy < BUF_DEPTH. Internal overflow is impossible by construction; the bench asserts it.
- Capture: deq_r is sender_deq registered (cleared by rst). When deq_r=1, {sender_data, sender_count, sender_last} is written into the word buffer at the write pointer.
- Read latency: exactly 1 cycle from sender_deq to capture; the first lane can be enqueued the cycle after capture, i.e. 2 cycles after sender_deq.
- Head word emission: lane index k runs 0..count-1. Physical lane is k (LANE_ORDER=0) or FETCH_WIDTH-1-k (LANE_ORDER=1).
- receiver_enq = !rst && receiver_full_n && buffer non-empty && head count != 0.
- receiver_data = selected lane of the head word; it is don't-care when receiver_enq=0.
- On each receiver_enq, k increments. When k == count-1, k returns to 0, the head is popped and the word retires.
- receiver_last = receiver_enq && k == count-1 && head last.
- Count 0: the head retires in one cycle with no enq. If its last flag is set, the frame end is lost (documented; an upstream encoder must not send it).
- Count > FETCH_WIDTH: clamped to FETCH_WIDTH.
- Pointer wrap: read/write pointers wrap at BUF_DEPTH (modulo, not a power-of-2 mask).
- Throughput: with BUF_DEPTH >= 2, source never empty and receiver never full, output is one lane per cycle with no bubbles at word boundaries after the initial 2-cycle fill.
- Back-pressure: receiver_full_n=0 holds k and the head word; receiver_data stays stable.

Test Plan:
- Single word, data 0x4444_3333_2222_1111 (DATA_WIDTH=16, FETCH_WIDTH=4), count=4, last=1, LANE_ORDER=0 -> enq 2 cycles after deq, emitting 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; receiver_last only with 0x4444.
- Same word with LANE_ORDER=1 -> 0x4444, 0x3333, 0x2222, 0x1111; last on 0x1111.
- Partial word, count=2, last=1, followed by a full word -> 0x1111, 0x2222(last), then next word's lanes with no gap; occupancy returns to 0.
- Ten back-to-back full words, BUF_DEPTH=3 -> 40 consecutive enq cycles; occupancy never exceeds 3; sender_deq drops when occupancy=3.
- receiver_full_n low for 5 cycles mid-word -> receiver_enq=0 and data held; resumes at the same lane; no loss or duplication; FETCH_WIDTH=3, BUF_DEPTH=5 variant also passes (non-power-of-2 wrap).
- rst asserted for one cycle while 2 words are buffered and 1 is in flight -> next cycle occupancy=0, no enq; the stale return is ignored; a subsequent word is emitted correctly.
